// File: rtl/ram_uart_loader_pkg.sv
// Shared command codes, FSM state encoding and length decode for the
// UART-to-RAM loader.
package ram_uart_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam int         LEN_WIDTH = 9;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_ADDR_H       = 4'd1,
    ST_ADDR_L       = 4'd2,
    ST_LEN          = 4'd3,
    ST_WRITE_DATA   = 4'd4,
    ST_READ_ISSUE   = 4'd5,
    ST_READ_WAIT    = 4'd6,
    ST_READ_CAPTURE = 4'd7,
    ST_READ_SEND    = 4'd8
  } state_t;

  // A length byte of zero stands for a full 256-byte burst.
  function automatic logic [LEN_WIDTH-1:0] decode_len(input logic [7:0] len_byte);
    if (len_byte == 8'd0) begin
      return 9'd256;
    end else begin
      return {1'b0, len_byte};
    end
  endfunction

endpackage

// File: rtl/ram_uart_loader.sv
// Byte-stream command engine: decodes 'W'/'R' transactions from a UART
// receiver into RAM write/read strobes and streams read data to a UART transmitter.
module ram_uart_loader
  import ram_uart_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [7:0]               RxData_i,
  input  logic                     RxValid_i,
  output logic [7:0]               TxData_o,
  output logic                     TxStart_o,
  input  logic                     TxBusy_i,
  output logic                     RamReadEnable_o,
  output logic                     RamWriteEnable_o,
  output logic [ADDRESS_WIDTH-1:0] RamAddress_o,
  output logic [DATA_WIDTH-1:0]    RamData_o,
  input  logic [DATA_WIDTH-1:0]    RamData_i,
  output logic                     Busy_o,
  output logic                     Error_o
);

  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  state_t                   state_r;
  logic                     mode_write_r;
  logic [7:0]               addr_h_r;
  logic [ADDRESS_WIDTH-1:0] ptr_r;
  logic [LEN_WIDTH-1:0]     count_r;
  logic [15:0]              full_addr_s;

  assign full_addr_s = {addr_h_r, RxData_i};

  // Transaction FSM; strobes default low each cycle so every pulse lasts exactly one cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r          <= ST_IDLE;
      mode_write_r     <= 1'b0;
      addr_h_r         <= 8'd0;
      ptr_r            <= '0;
      count_r          <= '0;
      TxData_o         <= 8'd0;
      TxStart_o        <= 1'b0;
      RamReadEnable_o  <= 1'b0;
      RamWriteEnable_o <= 1'b0;
      RamAddress_o     <= '0;
      RamData_o        <= '0;
      Busy_o           <= 1'b0;
      Error_o          <= 1'b0;
    end else begin
      TxStart_o        <= 1'b0;
      RamReadEnable_o  <= 1'b0;
      RamWriteEnable_o <= 1'b0;
      Error_o          <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (RxValid_i) begin
            if (RxData_i == CMD_WRITE) begin
              mode_write_r <= 1'b1;
              state_r      <= ST_ADDR_H;
              Busy_o       <= 1'b1;
            end else if (RxData_i == CMD_READ) begin
              mode_write_r <= 1'b0;
              state_r      <= ST_ADDR_H;
              Busy_o       <= 1'b1;
            end else begin
              Error_o <= 1'b1;
            end
          end
        end
        ST_ADDR_H: begin
          if (RxValid_i) begin
            addr_h_r <= RxData_i;
            state_r  <= ST_ADDR_L;
          end
        end
        ST_ADDR_L: begin
          if (RxValid_i) begin
            ptr_r   <= full_addr_s[ADDRESS_WIDTH-1:0];
            state_r <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (RxValid_i) begin
            count_r <= decode_len(RxData_i);
            state_r <= mode_write_r ? ST_WRITE_DATA : ST_READ_ISSUE;
          end
        end
        ST_WRITE_DATA: begin
          if (RxValid_i) begin
            RamWriteEnable_o <= 1'b1;
            RamData_o        <= RxData_i;
            RamAddress_o     <= ptr_r;
            ptr_r            <= ptr_r + PTR_ONE;
            count_r          <= count_r - 9'd1;
            if (count_r == 9'd1) begin
              state_r <= ST_IDLE;
              Busy_o  <= 1'b0;
            end
          end
        end
        ST_READ_ISSUE: begin
          RamReadEnable_o <= 1'b1;
          RamAddress_o    <= ptr_r;
          state_r         <= ST_READ_WAIT;
        end
        // The RAM samples the read strobe at the end of this cycle.
        ST_READ_WAIT: begin
          state_r <= ST_READ_CAPTURE;
        end
        ST_READ_CAPTURE: begin
          TxData_o <= RamData_i;
          state_r  <= ST_READ_SEND;
        end
        ST_READ_SEND: begin
          if (!TxBusy_i) begin
            TxStart_o <= 1'b1;
            ptr_r     <= ptr_r + PTR_ONE;
            count_r   <= count_r - 9'd1;
            if (count_r == 9'd1) begin
              state_r <= ST_IDLE;
              Busy_o  <= 1'b0;
            end else begin
              state_r <= ST_READ_ISSUE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          Busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_uart_loader.sv
// Directed bench for ram_uart_loader: table-driven write vectors plus
// hand-written read, wrap, length-0, error and reset sequences.
module tb_ram_uart_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  RxData_i = 8'd0;
  logic        RxValid_i = 1'b0;
  logic [7:0]  TxData_o;
  logic        TxStart_o;
  logic        TxBusy_i;
  logic        RamReadEnable_o;
  logic        RamWriteEnable_o;
  logic [15:0] RamAddress_o;
  logic [7:0]  RamData_o;
  logic [7:0]  RamData_i = 8'd0;
  logic        Busy_o;
  logic        Error_o;

  ram_uart_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .RxData_i(RxData_i), .RxValid_i(RxValid_i),
    .TxData_o(TxData_o), .TxStart_o(TxStart_o), .TxBusy_i(TxBusy_i),
    .RamReadEnable_o(RamReadEnable_o), .RamWriteEnable_o(RamWriteEnable_o),
    .RamAddress_o(RamAddress_o), .RamData_o(RamData_o), .RamData_i(RamData_i),
    .Busy_o(Busy_o), .Error_o(Error_o)
  );

  always #5 Clock = ~Clock;

  // RAM model with registered read data
  logic [7:0] mem [0:65535];
  always @(posedge Clock) begin
    if (RamWriteEnable_o) mem[RamAddress_o] <= RamData_o;
    if (RamReadEnable_o) RamData_i <= mem[RamAddress_o];
  end

  // Transmitter model: busy for 10 cycles after each start
  int   tx_busy_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge Clock) begin
    if (TxStart_o) tx_busy_cnt <= 10;
    else if (tx_busy_cnt > 0) tx_busy_cnt <= tx_busy_cnt - 1;
  end
  assign TxBusy_i = force_busy | (tx_busy_cnt != 0);

  // Event monitor
  int         cyc = 0, we_cnt = 0, re_cnt = 0, tx_cnt = 0, err_cnt = 0, overlap = 0;
  int         re_last_cyc = 0, tx_lat = 0;
  logic [15:0] re_log [0:1023];
  logic [7:0]  tx_log [0:1023];
  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (RamWriteEnable_o) we_cnt = we_cnt + 1;
    if (RamWriteEnable_o && RamReadEnable_o) overlap = overlap + 1;
    if (Error_o) err_cnt = err_cnt + 1;
    if (RamReadEnable_o) begin
      re_log[re_cnt] = RamAddress_o;
      re_cnt = re_cnt + 1;
      re_last_cyc = cyc;
    end
    if (TxStart_o) begin
      tx_log[tx_cnt] = TxData_o;
      tx_cnt = tx_cnt + 1;
      tx_lat = cyc - re_last_cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RxData_i = b;
    RxValid_i = 1'b1;
    step();
    RxValid_i = 1'b0;
    RxData_i = 8'd0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " TxData"}, {24'd0, TxData_o}, 32'd0);
    check({nm, " TxStart"}, {31'd0, TxStart_o}, 32'd0);
    check({nm, " RamRe"}, {31'd0, RamReadEnable_o}, 32'd0);
    check({nm, " RamWe"}, {31'd0, RamWriteEnable_o}, 32'd0);
    check({nm, " RamAddr"}, {16'd0, RamAddress_o}, 32'd0);
    check({nm, " RamData"}, {24'd0, RamData_o}, 32'd0);
    check({nm, " Busy"}, {31'd0, Busy_o}, 32'd0);
    check({nm, " Error"}, {31'd0, Error_o}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  rx;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        busy;
  } vec_t;
  vec_t tbl [$];

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_byte(tbl[i].rx);
      check($sformatf("row%0d we", i), {31'd0, RamWriteEnable_o}, {31'd0, tbl[i].we});
      check($sformatf("row%0d busy", i), {31'd0, Busy_o}, {31'd0, tbl[i].busy});
      check($sformatf("row%0d err", i), {31'd0, Error_o}, 32'd0);
      if (tbl[i].we) begin
        check($sformatf("row%0d addr", i), {16'd0, RamAddress_o}, {16'd0, tbl[i].addr});
        check($sformatf("row%0d data", i), {24'd0, RamData_o}, {24'd0, tbl[i].data});
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (Busy_o && n < 100) begin
      step();
      n++;
    end
    check({nm, " idle"}, {31'd0, Busy_o}, 32'd0);
  endtask

  task automatic do_read(input string nm, input logic [15:0] a, input int n,
                         input logic [7:0] e0, input logic [7:0] e1);
    int base_tx, base_re, t;
    logic [15:0] a1;
    a1 = a + 16'd1;
    base_tx = tx_cnt;
    base_re = re_cnt;
    send_byte(8'h52);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(n[7:0]);
    check({nm, " re not yet"}, {31'd0, RamReadEnable_o}, 32'd0);
    step();
    check({nm, " re latency"}, {31'd0, RamReadEnable_o}, 32'd1);
    check({nm, " re addr0"}, {16'd0, RamAddress_o}, {16'd0, a});
    t = 0;
    while ((tx_cnt - base_tx) < n && t < 300) begin
      step();
      t++;
    end
    check({nm, " tx count"}, tx_cnt - base_tx, n);
    wait_idle(nm);
    check({nm, " re count"}, re_cnt - base_re, n);
    check({nm, " byte0"}, {24'd0, tx_log[base_tx]}, {24'd0, e0});
    check({nm, " re>=3 to start"}, {31'd0, tx_lat >= 3}, 32'd1);
    if (n > 1) begin
      check({nm, " byte1"}, {24'd0, tx_log[base_tx+1]}, {24'd0, e1});
      check({nm, " re addr1"}, {16'd0, re_log[base_re+1]}, {16'd0, a1});
      check({nm, " txdata hold"}, {24'd0, TxData_o}, {24'd0, e1});
    end
  endtask

  initial begin
    int base_we, base_re, base_tx, base_err, t;

    // test 1 write
    tbl.push_back('{8'h57, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h12, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h34, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h02, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'hAA, 1'b1, 16'h1234, 8'hAA, 1'b1});
    tbl.push_back('{8'hBB, 1'b1, 16'h1235, 8'hBB, 1'b0});
    // test 3 wrap write
    tbl.push_back('{8'h57, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'hFF, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'hFF, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h02, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h11, 1'b1, 16'hFFFF, 8'h11, 1'b1});
    tbl.push_back('{8'h22, 1'b1, 16'h0000, 8'h22, 1'b0});
    // test 6 head: write interrupted by reset
    tbl.push_back('{8'h57, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h10, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'h03, 1'b0, 16'h0000, 8'h00, 1'b1});
    tbl.push_back('{8'hCC, 1'b1, 16'h0010, 8'hCC, 1'b1});

    Reset = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    Reset = 1'b1;
    step();

    apply_rows(0, 5);
    do_read("rd1234", 16'h1234, 2, 8'hAA, 8'hBB);

    apply_rows(6, 11);
    do_read("rdwrap", 16'hFFFF, 2, 8'h11, 8'h22);

    // length 0 means 256 bytes
    base_we = we_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i) ^ 8'hA5);
      check($sformatf("len0 we%0d", i), {31'd0, RamWriteEnable_o}, 32'd1);
      check($sformatf("len0 addr%0d", i), {16'd0, RamAddress_o}, i);
      check($sformatf("len0 data%0d", i), {24'd0, RamData_o}, {24'd0, 8'(i) ^ 8'hA5});
      check($sformatf("len0 busy%0d", i), {31'd0, Busy_o}, (i == 255) ? 32'd0 : 32'd1);
    end
    step();
    check("len0 pulses", we_cnt - base_we, 256);

    // unknown command
    base_we = we_cnt;
    base_re = re_cnt;
    send_byte(8'h41);
    check("err pulse", {31'd0, Error_o}, 32'd1);
    check("err busy", {31'd0, Busy_o}, 32'd0);
    step();
    check("err one cycle", {31'd0, Error_o}, 32'd0);
    check("err busy after", {31'd0, Busy_o}, 32'd0);
    step();
    check("err no we", we_cnt - base_we, 0);
    check("err no re", re_cnt - base_re, 0);
    do_read("rdafter_err", 16'h0000, 1, 8'hA5, 8'h00);

    // reset aborts a write mid-burst
    base_we = we_cnt;
    base_tx = tx_cnt;
    apply_rows(12, 16);
    Reset = 1'b0;
    RxData_i = 8'hDD;
    RxValid_i = 1'b1;
    step();
    RxValid_i = 1'b0;
    RxData_i = 8'd0;
    step();
    check_reset_outputs("midreset");
    Reset = 1'b1;
    repeat (5) step();
    check("midreset one write", we_cnt - base_we, 1);
    check("midreset no tx", tx_cnt - base_tx, 0);
    check("midreset idle", {31'd0, Busy_o}, 32'd0);

    // transmitter held busy: FSM must stall in READ_SEND
    force_busy = 1'b1;
    base_tx = tx_cnt;
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34); send_byte(8'h01);
    repeat (20) step();
    check("hold no start", tx_cnt - base_tx, 0);
    check("hold busy", {31'd0, Busy_o}, 32'd1);
    check("hold captured", {24'd0, TxData_o}, 32'h0000_00AA);
    force_busy = 1'b0;
    t = 0;
    while (tx_cnt == base_tx && t < 50) begin
      step();
      t++;
    end
    check("release start", tx_cnt - base_tx, 1);
    check("release data", {24'd0, tx_log[base_tx]}, 32'h0000_00AA);
    wait_idle("release");

    base_err = err_cnt;
    check("error pulses total", base_err, 1);
    check("we/re overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
